// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared state encoding for the RAM arbiter
package ram_arbiter_pkg;

  localparam int STATE_WIDTH = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    RAM_ARB_IDLE      = 3'd0,
    RAM_ARB_ISSUE_IF  = 3'd1,
    RAM_ARB_ISSUE_MEM = 3'd2,
    RAM_ARB_RESP_IF   = 3'd3,
    RAM_ARB_RESP_MEM  = 3'd4
  } ram_arb_state_t;

endpackage

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one single-port synchronous RAM between fetch and data ports
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SEL_WIDTH    = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  mem_req,
  input  logic [SEL_WIDTH-1:0]  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_ack,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  ram_en,
  output logic [SEL_WIDTH-1:0]  ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  output logic                  stall_req
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  ram_arb_state_t   state;
  logic [CNT_W-1:0] starve_cnt;
  logic             grant_if;
  logic             grant_mem;

  // Data wins by default; fetch takes over when alone or once it has starved long enough.
  assign grant_if  = if_req & (~mem_req | (starve_cnt == STARVE_MAX));
  assign grant_mem = mem_req & ~grant_if;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= RAM_ARB_IDLE;
      ram_en         <= 1'b0;
      ram_write_en   <= '0;
      ram_addr       <= '0;
      ram_write_data <= '0;
    end else begin
      case (state)
        RAM_ARB_IDLE: begin
          if (grant_if) begin
            state          <= RAM_ARB_ISSUE_IF;
            ram_en         <= 1'b1;
            ram_write_en   <= '0;
            ram_addr       <= if_addr;
            ram_write_data <= '0;
          end else if (grant_mem) begin
            state          <= RAM_ARB_ISSUE_MEM;
            ram_en         <= 1'b1;
            ram_write_en   <= mem_we;
            ram_addr       <= mem_addr;
            ram_write_data <= mem_wdata;
          end
        end
        RAM_ARB_ISSUE_IF, RAM_ARB_ISSUE_MEM: begin
          state          <= (state == RAM_ARB_ISSUE_IF) ? RAM_ARB_RESP_IF : RAM_ARB_RESP_MEM;
          ram_en         <= 1'b0;
          ram_write_en   <= '0;
          ram_addr       <= '0;
          ram_write_data <= '0;
        end
        default: state <= RAM_ARB_IDLE;
      endcase
    end
  end

  // Counts data grants that bypassed a waiting fetch; saturates so the force condition holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == RAM_ARB_IDLE) begin
      if (grant_if) begin
        starve_cnt <= '0;
      end else if (grant_mem && if_req && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign if_ack    = (state == RAM_ARB_RESP_IF);
  assign mem_ack   = (state == RAM_ARB_RESP_MEM);
  assign if_rdata  = if_ack  ? ram_read_data : '0;
  assign mem_rdata = mem_ack ? ram_read_data : '0;
  assign stall_req = (if_req & ~if_ack) | (mem_req & ~mem_ack);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with a behavioural RAM
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_req = 1'b0;
  logic [3:0]  mem_we = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data = '0;
  logic        stall_req;

  ram_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
    .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_if;
    bit          chk_data;
    logic [31:0] data;
  } ack_t;

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } iss_t;

  ack_t ack_q[$];
  iss_t iss_q[$];
  ack_t mon_ack;
  iss_t mon_iss;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int if_ack_cyc = 0;
  int mem_ack_cyc = 0;
  int mem_ack_n = 0;
  int c0;
  int n0;

  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] rd_tmp;
  logic [31:0] wr_tmp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM: read-before-write, data one cycle after ram_en.
  always @(posedge clk) begin
    if (ram_en) begin
      rd_tmp = ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : 32'h0;
      wr_tmp = rd_tmp;
      for (int b = 0; b < 4; b++)
        if (ram_write_en[b]) wr_tmp[8*b +: 8] = ram_write_data[8*b +: 8];
      ram_mem[ram_addr] = wr_tmp;
      ram_read_data <= rd_tmp;
    end
  end

  // Monitor: compares RAM issues and acks against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst && (if_ack || mem_ack)) begin
      if (if_ack) if_ack_cyc <= cyc;
      if (mem_ack) begin
        mem_ack_cyc <= cyc;
        mem_ack_n   <= mem_ack_n + 1;
      end
      if (ack_q.size() == 0) begin
        chk("unexpected_ack", {30'b0, if_ack, mem_ack}, 32'd0);
      end else begin
        mon_ack = ack_q.pop_front();
        chk("ack_port", {30'b0, if_ack, mem_ack}, mon_ack.is_if ? 32'd2 : 32'd1);
        if (mon_ack.chk_data)
          chk("ack_data", mon_ack.is_if ? if_rdata : mem_rdata, mon_ack.data);
      end
    end
    if (!rst && ram_en) begin
      if (iss_q.size() == 0) begin
        chk("unexpected_issue", 32'(ram_en), 32'd0);
      end else begin
        mon_iss = iss_q.pop_front();
        chk("issue_addr", ram_addr, mon_iss.addr);
        chk("issue_we", 32'(ram_write_en), 32'(mon_iss.we));
        chk("issue_wdata", ram_write_data, mon_iss.wdata);
      end
    end
  end

  task automatic push_ack(input bit is_if, input bit chk_data, input logic [31:0] data);
    ack_t a;
    a.is_if = is_if; a.chk_data = chk_data; a.data = data;
    ack_q.push_back(a);
  endtask

  task automatic push_iss(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    iss_t i;
    i.we = we; i.addr = addr; i.wdata = wdata;
    iss_q.push_back(i);
  endtask

  task automatic wait_ack(input bit is_if, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_if ? if_ack : mem_ack) && n < 40);
    chk(name, 32'(is_if ? if_ack : mem_ack), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic mem_access(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                            input bit chk_data, input logic [31:0] rdata);
    push_iss(we, addr, wdata);
    push_ack(1'b0, chk_data, rdata);
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
    wait_ack(1'b0, "mem_timeout");
    mem_req = 1'b0; mem_we = '0; mem_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    ram_mem[32'h40]  = 32'h24020005;
    ram_mem[32'h100] = 32'h11223344;
    ram_mem[32'h200] = 32'hDEADBEEF;
    ram_mem[32'h300] = 32'hAAAAAAAA;

    repeat (3) @(negedge clk);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_bus", ram_addr | ram_write_data | 32'(ram_write_en), 32'd0);
    chk("rst_acks_stall", {29'b0, if_ack, mem_ack, stall_req}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Fetch only: issue in cycle 1, ack in cycle 2, stall drops with the ack.
    c0 = cyc;
    push_iss(4'b0000, 32'h40, 32'h0);
    push_ack(1'b1, 1'b1, 32'h24020005);
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    chk("fetch_c0_stall", 32'(stall_req), 32'd1);
    chk("fetch_c0_ram_en", 32'(ram_en), 32'd0);
    @(negedge clk);
    chk("fetch_c1_stall", 32'(stall_req), 32'd1);
    chk("fetch_c1_ram_en", 32'(ram_en), 32'd1);
    @(negedge clk);
    chk("fetch_c2_stall", 32'(stall_req), 32'd0);
    chk("fetch_c2_ack", 32'(if_ack), 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
    chk("fetch_ack_cycle", 32'(if_ack_cyc - c0), 32'd2);

    // Byte-lane write to lane 2, then read back the merged word.
    c0 = cyc;
    mem_access(4'b0100, 32'h100, 32'h00AB0000, 1'b0, 32'h0);
    chk("write_ack_cycle", 32'(mem_ack_cyc - c0), 32'd2);
    mem_access(4'b0000, 32'h100, 32'h0, 1'b1, 32'h11AB3344);

    // Starvation: data held continuously; fetch forced after four data grants.
    n0 = mem_ack_n;
    for (int k = 0; k < 4; k++) begin
      push_iss(4'b0000, 32'h200, 32'h0);
      push_ack(1'b0, 1'b1, 32'hDEADBEEF);
    end
    push_iss(4'b0000, 32'h40, 32'h0);
    push_ack(1'b1, 1'b1, 32'h24020005);
    mem_req = 1'b1; mem_we = '0; mem_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h40;
    wait_ack(1'b1, "starve_timeout");
    mem_req = 1'b0; if_req = 1'b0;
    chk("starve_mem_acks", 32'(mem_ack_n - n0), 32'd4);

    // Simultaneous after a fetch grant: counter cleared, so data wins first.
    c0 = cyc;
    push_iss(4'b0000, 32'h200, 32'h0);
    push_iss(4'b0000, 32'h40, 32'h0);
    push_ack(1'b0, 1'b1, 32'hDEADBEEF);
    push_ack(1'b1, 1'b1, 32'h24020005);
    fork
      begin
        mem_req = 1'b1; mem_addr = 32'h200; mem_we = '0;
        wait_ack(1'b0, "sim_mem_timeout");
        mem_req = 1'b0;
      end
      begin
        if_req = 1'b1; if_addr = 32'h40;
        wait_ack(1'b1, "sim_if_timeout");
        if_req = 1'b0;
      end
    join
    chk("sim_mem_ack_cycle", 32'(mem_ack_cyc - c0), 32'd2);
    chk("sim_if_ack_cycle", 32'(if_ack_cyc - c0), 32'd5);

    // Asynchronous reset during ISSUE_MEM drops the write; it is re-served after release.
    mem_req = 1'b1; mem_we = 4'b0011; mem_addr = 32'h300; mem_wdata = 32'h00005566;
    @(posedge clk); #1;
    chk("pre_rst_write_en", 32'(ram_write_en), 32'h3);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_ram_en", 32'(ram_en), 32'd0);
    chk("rst_async_write_en", 32'(ram_write_en), 32'd0);
    chk("rst_async_acks", {30'b0, if_ack, mem_ack}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    push_iss(4'b0011, 32'h300, 32'h00005566);
    push_ack(1'b0, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_resume_c1_ack", 32'(mem_ack), 32'd0);
    @(negedge clk);
    chk("rst_resume_c2_ack", 32'(mem_ack), 32'd1);
    @(posedge clk); #1;
    mem_req = 1'b0; mem_we = '0; mem_wdata = '0;
    mem_access(4'b0000, 32'h300, 32'h0, 1'b1, 32'hAAAA5566);

    // Idle: nothing moves for ten cycles.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_quiet", {28'b0, ram_en, stall_req, if_ack, mem_ack}, 32'd0);
    end

    chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
    chk("iss_q_drained", 32'(iss_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one single-port synchronous RAM between two requesters: the instruction-fetch port and the data port coming out of the MEM stage (ram_en, ram_write_en, ram_addr, ram_write_data).
- Serializes accesses, returns read data, and raises stall_req to pipeline control while any request is unserved.
- Data port has priority by default.
- A starvation counter guarantees that fetch is eventually granted.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
SEL_WIDTH, 4, byte-enable width
STARVE_LIMIT, 4, consecutive data grants with fetch pending before fetch is forced

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  ADDR_WIDTH  fetch word address
if_ack  out  1  one-cycle fetch completion
if_rdata  out  DATA_WIDTH  fetch data, valid with if_ack
mem_req  in  1  data request (MEM-stage ram_en), held until mem_ack
mem_we  in  SEL_WIDTH  byte write enables; 0 means read
mem_addr  in  ADDR_WIDTH  word-aligned data address
mem_wdata  in  DATA_WIDTH  lane-positioned write data
mem_ack  out  1  one-cycle data completion
mem_rdata  out  DATA_WIDTH  read data, valid with mem_ack
ram_en  out  1  RAM enable
ram_write_en  out  SEL_WIDTH  RAM byte write enables
ram_addr  out  ADDR_WIDTH  RAM address
ram_write_data  out  DATA_WIDTH  RAM write data
ram_read_data  in  DATA_WIDTH  RAM read data, valid the cycle after ram_en
stall_req  out  1  pipeline stall request

Behaviour:
- Single clock domain (clk). Reset is asynchronous and active-high (rst).
- FSM states: IDLE, ISSUE_IF, ISSUE_MEM, RESP_IF, RESP_MEM.

State transitions:
- IDLE, no requests: stay in IDLE.
- IDLE, requests pending: select a winner and move to ISSUE_x.
- Winner selection: mem_req wins unless (if_req && starve_cnt == STARVE_LIMIT).
- ISSUE_x -> RESP_x unconditionally.
- RESP_x -> IDLE unconditionally.
- The just-acked requester's still-high req is therefore never re-served in the same cycle.

Issue registration:
- On the IDLE->ISSUE edge, ram_en, ram_write_en, ram_addr and ram_write_data are loaded into registers.
- Fetch winner: ram_write_en = 0, ram_write_data = 0.
- Data winner: mem_we and mem_wdata are copied.
- The registers are cleared to 0 on ISSUE->RESP.
- RAM outputs are therefore nonzero only in ISSUE states.

Response:
- if_ack = (state == RESP_IF) and mem_ack = (state == RESP_MEM); both are decoded from the registered state.
- In RESP_x, x_rdata = ram_read_data; otherwise 0.
- Writes also ack in RESP_MEM; mem_rdata is don't-care for writes.
- Latency: req sampled at edge 0, RAM access during cycle 1, ack during cycle 2. Minimum 3 cycles per access.

Starvation counter:
- starve_cnt has width $clog2(STARVE_LIMIT+1).
- It increments, saturating at STARVE_LIMIT, on every data grant while if_req = 1.
- It clears on every fetch grant.
- It is held otherwise.

Stall:
- stall_req = (if_req & ~if_ack) | (mem_req & ~mem_ack), combinational.

Reset:
- rst = 1 immediately forces state IDLE, starve_cnt 0, and all registered outputs 0.
- A reset mid-access drops the in-flight access with no ack. Requesters keep req high and are re-served after release.

Protocol violation:
- If req drops before ack, the issued access still completes and the ack still pulses. The requester must ignore it.

Decomposition:
- The shared defines header carries the state-encoding width and the five state constants (RAM_ARB_IDLE, etc.). It reuses the existing ADDR_BUS, DATA_BUS and MEM_SEL_BUS ranges.
- No sub-module is required. The starvation counter is roughly 15 lines inline.

Test Plan:
- Fetch only: if_req=1, if_addr=0x00000040, RAM returns 0x24020005 -> cycle 1: ram_en=1, ram_addr=0x40, ram_write_en=0. Cycle 2: if_ack=1, if_rdata=0x24020005. stall_req=1 in cycles 0-1 and 0 in cycle 2.
- Data byte write: mem_req=1, mem_we=0100, mem_addr=0x100, mem_wdata=0x00AB0000 -> cycle 1: ram_write_en=0100, ram_write_data=0x00AB0000. Cycle 2: mem_ack=1. No if_ack.
- Simultaneous: if_req=mem_req=1 at cycle 0 -> mem_ack in cycle 2, if_ack in cycle 5. ram_addr in cycle 4 equals if_addr.
- Starvation: STARVE_LIMIT=4, mem_req re-asserted continuously, if_req held -> four mem_ack pulses, then if_ack, then starve_cnt=0.
- Reset during ISSUE_MEM (rst asserted mid-cycle) -> ram_en, ram_write_en and the acks go to 0 without waiting for a clock. After release with mem_req held, mem_ack arrives 2 cycles after the first edge in IDLE.
- Idle: no requests for 10 cycles -> ram_en=0, stall_req=0, both acks 0 throughout.
